// File: rtl/adv7513_config_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : adv7513_config_sequencer_if
//  Purpose  : Byte-write handshake between the ADV7513 configuration
//             sequencer (master) and the shared I2C byte-write engine (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface adv7513_config_sequencer_if;
    logic       WR_REQ;     // write request, held until WR_DONE
    logic [7:0] WR_REG;     // target register address
    logic [7:0] WR_DATA;    // data byte
    logic       WR_DONE;    // one-cycle completion pulse
    logic       WR_NACK;    // valid with WR_DONE, 1 = not acknowledged

    modport master (
        output WR_REQ, WR_REG, WR_DATA,
        input  WR_DONE, WR_NACK
    );

    modport slave (
        input  WR_REQ, WR_REG, WR_DATA,
        output WR_DONE, WR_NACK
    );
endinterface
`default_nettype wire

// File: rtl/adv7513_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : adv7513_config_sequencer
//  Purpose  : Walks the ADV7513 configuration ROM after a power-up settle
//             delay, writing each {reg, data} word through the I2C byte-write
//             engine with bounded NACK retry. Raises ready when the whole
//             table is written; a hot-plug interrupt clears the interrupt
//             status and replays the table.
//  Revision : 1.0  initial release
// ============================================================================
module adv7513_config_sequencer #(
    parameter int         NUM_OF_CONFIG = 14,
    parameter int         ADDR_WIDTH    = 4,
    parameter int         PWR_DELAY     = 50000,
    parameter int         DELAY_WIDTH   = 16,
    parameter int         MAX_RETRY     = 3,
    parameter logic [7:0] INT_CLR_REG   = 8'h96,
    parameter logic [7:0] INT_CLR_DATA  = 8'hC0
) (
    input  wire logic                    CLK_I2C,
    input  wire logic                    RST_n,
    input  wire logic                    START,
    input  wire logic                    HDMI_INT,
    input  wire logic [15:0]             CONFIG,
    output      logic [ADDR_WIDTH-1:0]   config_addr,
    adv7513_config_sequencer_if.master   wr_bus,
    output      logic                    ready,
    output      logic                    error
);

    localparam int c_RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [c_RETRY_W-1:0]   c_MAX_RETRY  = c_RETRY_W'(MAX_RETRY);
    localparam logic [ADDR_WIDTH-1:0]  c_LAST_ADDR  = ADDR_WIDTH'(NUM_OF_CONFIG - 1);
    localparam logic [DELAY_WIDTH-1:0] c_DELAY_LAST = DELAY_WIDTH'(PWR_DELAY - 1);

    typedef enum logic [2:0] {
        S_PWR_WAIT = 3'd0,
        S_LOAD     = 3'd1,
        S_WAIT_WR  = 3'd2,
        S_NEXT     = 3'd3,
        S_DONE     = 3'd4,
        S_INT_CLR  = 3'd5,
        S_INT_WAIT = 3'd6,
        S_ERROR    = 3'd7
    } state_t;

    state_t                  r_state;
    logic [DELAY_WIDTH-1:0]  r_delay;
    logic [c_RETRY_W-1:0]    r_retry;
    logic [ADDR_WIDTH-1:0]   r_config_addr;
    logic                    r_wr_req;
    logic [7:0]              r_wr_reg;
    logic [7:0]              r_wr_data;
    logic                    r_ready;
    logic                    r_error;
    logic                    r_int_pending;
    logic                    r_int_s1;
    logic                    r_int_s2;
    logic                    r_int_s3;
    logic                    w_int_fall;

    // Synchronise the active-low interrupt; idle level is high so reset to 1
    always_ff @(posedge CLK_I2C or negedge RST_n) begin
        if (!RST_n) begin
            r_int_s1 <= 1'b1;
            r_int_s2 <= 1'b1;
            r_int_s3 <= 1'b1;
        end else begin
            r_int_s1 <= HDMI_INT;
            r_int_s2 <= r_int_s1;
            r_int_s3 <= r_int_s2;
        end
    end

    assign w_int_fall = r_int_s3 & ~r_int_s2;

    // Configuration sequencer: delay, ROM walk with retry, interrupt replay
    always_ff @(posedge CLK_I2C or negedge RST_n) begin
        if (!RST_n) begin
            r_state       <= S_PWR_WAIT;
            r_delay       <= '0;
            r_retry       <= '0;
            r_config_addr <= '0;
            r_wr_req      <= 1'b0;
            r_wr_reg      <= 8'h00;
            r_wr_data     <= 8'h00;
            r_ready       <= 1'b0;
            r_error       <= 1'b0;
            r_int_pending <= 1'b0;
        end else if (START) begin
            // Restart wins over everything, including a coincident interrupt
            r_state       <= S_PWR_WAIT;
            r_delay       <= '0;
            r_retry       <= '0;
            r_wr_req      <= 1'b0;
            r_ready       <= 1'b0;
            r_error       <= 1'b0;
            r_int_pending <= 1'b0;
        end else begin
            if (w_int_fall) begin
                r_int_pending <= 1'b1;
            end
            case (r_state)
                S_PWR_WAIT: begin
                    if (r_delay == c_DELAY_LAST) begin
                        r_delay       <= '0;
                        r_config_addr <= '0;
                        r_state       <= S_LOAD;
                    end else begin
                        r_delay <= r_delay + 1'b1;
                    end
                end
                S_LOAD: begin
                    r_wr_reg  <= CONFIG[15:8];
                    r_wr_data <= CONFIG[7:0];
                    r_wr_req  <= 1'b1;
                    r_state   <= S_WAIT_WR;
                end
                S_WAIT_WR: begin
                    if (wr_bus.WR_DONE) begin
                        r_wr_req <= 1'b0;
                        if (!wr_bus.WR_NACK) begin
                            r_retry <= '0;
                            r_state <= S_NEXT;
                        end else if (r_retry < c_MAX_RETRY) begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= S_LOAD;
                        end else begin
                            r_error <= 1'b1;
                            r_ready <= 1'b0;
                            r_state <= S_ERROR;
                        end
                    end
                end
                S_NEXT: begin
                    if (r_config_addr == c_LAST_ADDR) begin
                        r_ready <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_config_addr <= r_config_addr + 1'b1;
                        r_state       <= S_LOAD;
                    end
                end
                S_DONE: begin
                    if (r_int_pending) begin
                        r_ready       <= 1'b0;
                        // A fresh edge landing now must not be lost
                        r_int_pending <= w_int_fall;
                        r_state       <= S_INT_CLR;
                    end
                end
                S_INT_CLR: begin
                    r_wr_reg  <= INT_CLR_REG;
                    r_wr_data <= INT_CLR_DATA;
                    r_wr_req  <= 1'b1;
                    r_state   <= S_INT_WAIT;
                end
                S_INT_WAIT: begin
                    if (wr_bus.WR_DONE) begin
                        r_wr_req <= 1'b0;
                        if (!wr_bus.WR_NACK) begin
                            // Replay immediately: the transmitter is already powered
                            r_retry <= '0;
                            r_delay <= c_DELAY_LAST;
                            r_state <= S_PWR_WAIT;
                        end else if (r_retry < c_MAX_RETRY) begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= S_INT_CLR;
                        end else begin
                            r_error <= 1'b1;
                            r_ready <= 1'b0;
                            r_state <= S_ERROR;
                        end
                    end
                end
                S_ERROR: begin
                    r_error  <= 1'b1;
                    r_ready  <= 1'b0;
                    r_wr_req <= 1'b0;
                end
                default: begin
                    r_state <= S_PWR_WAIT;
                end
            endcase
        end
    end

    assign config_addr    = r_config_addr;
    assign wr_bus.WR_REQ  = r_wr_req;
    assign wr_bus.WR_REG  = r_wr_reg;
    assign wr_bus.WR_DATA = r_wr_data;
    assign ready          = r_ready;
    assign error          = r_error;

endmodule
`default_nettype wire

// File: tb/tb_adv7513_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adv7513_config_sequencer
//  Purpose  : Self-checking bench for adv7513_config_sequencer. A randomly
//             timed I2C engine model answers requests from a per-register
//             NACK table; expected write streams come from a table-walk model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adv7513_config_sequencer;

    localparam int NUM_CFG   = 14;
    localparam int MAX_RETRY = 3;
    localparam int PWR_DELAY = 4;
    localparam int BUDGET    = 3000;

    logic        clk = 1'b0;
    logic        RST_n;
    logic        START;
    logic        HDMI_INT;
    logic [15:0] cfg_word;
    logic [3:0]  cfg_addr;
    logic        ready;
    logic        error;

    adv7513_config_sequencer_if bus();

    adv7513_config_sequencer #(
        .NUM_OF_CONFIG (NUM_CFG),
        .ADDR_WIDTH    (4),
        .PWR_DELAY     (PWR_DELAY),
        .DELAY_WIDTH   (16),
        .MAX_RETRY     (MAX_RETRY),
        .INT_CLR_REG   (8'h96),
        .INT_CLR_DATA  (8'hC0)
    ) dut (
        .CLK_I2C     (clk),
        .RST_n       (RST_n),
        .START       (START),
        .HDMI_INT    (HDMI_INT),
        .CONFIG      (cfg_word),
        .config_addr (cfg_addr),
        .wr_bus      (bus),
        .ready       (ready),
        .error       (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Configuration ROM (register addresses are unique and exclude 0x96)
    logic [15:0] rom [0:15];
    assign cfg_word = rom[cfg_addr];

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] obs_q [$];
    logic [15:0] exp_q [$];
    bit          exp_err;
    int          plan [0:15];
    int          nack_tbl [0:255];
    int          last_done_cyc = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    endtask

    // I2C engine model: accepts a request, answers after 1..4 cycles
    bit         eng_busy = 1'b0;
    int         eng_lat  = 0;
    logic [7:0] eng_reg  = 8'h00;
    initial begin
        bus.WR_DONE = 1'b0;
        bus.WR_NACK = 1'b0;
        forever begin
            @(negedge clk);
            bus.WR_DONE = 1'b0;
            bus.WR_NACK = 1'b0;
            if (!RST_n) begin
                eng_busy = 1'b0;
            end else if (eng_busy) begin
                eng_lat--;
                if (eng_lat == 0) begin
                    eng_busy    = 1'b0;
                    bus.WR_DONE = 1'b1;
                    last_done_cyc = cyc;
                    if (nack_tbl[eng_reg] > 0) begin
                        bus.WR_NACK = 1'b1;
                        nack_tbl[eng_reg]--;
                    end
                end
            end else if (bus.WR_REQ) begin
                obs_q.push_back({bus.WR_REG, bus.WR_DATA});
                eng_reg  = bus.WR_REG;
                eng_busy = 1'b1;
                eng_lat  = $urandom_range(1, 4);
            end
        end
    end

    // Reference: each entry is attempted (nacks+1) times; more than
    // MAX_RETRY nacks ends the pass in error. Consumed nacks are cleared.
    function automatic void model_rom_pass();
        for (int i = 0; i < NUM_CFG; i++) begin
            int attempts;
            attempts = (plan[i] > MAX_RETRY) ? MAX_RETRY + 1 : plan[i] + 1;
            for (int a = 0; a < attempts; a++) exp_q.push_back(rom[i]);
            if (plan[i] > MAX_RETRY) begin
                plan[i] = 0;
                exp_err = 1'b1;
                return;
            end
            plan[i] = 0;
        end
    endfunction

    task automatic load_engine();
        for (int r = 0; r < 256; r++) nack_tbl[r] = 0;
        for (int i = 0; i < NUM_CFG; i++) nack_tbl[rom[i][15:8]] = plan[i];
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 16; i++) plan[i] = 0;
    endtask

    task automatic begin_expect();
        exp_q.delete();
        exp_err = 1'b0;
        obs_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
    endtask

    task automatic wait_settled(input string tag);
        int n;
        n = 0;
        while (!(ready || error) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!(ready || error)) check_value({tag, "_settle"}, {31'b0, ready | error}, 32'd1);
    endtask

    task automatic wait_obs(input string tag, input int target);
        int n;
        n = 0;
        while (obs_q.size() < target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (obs_q.size() < target) check_value({tag, "_obs"}, 32'(obs_q.size()), 32'(target));
    endtask

    task automatic compare_txns(input string tag);
        check_value({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_value($sformatf("%s_txn%0d", tag, i), {16'h0, obs_q[i]}, {16'h0, exp_q[i]});
        check_value({tag, "_error"}, {31'b0, error}, {31'b0, exp_err});
        check_value({tag, "_ready"}, {31'b0, ready}, {31'b0, ~exp_err});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_addr"},  {28'h0, cfg_addr},    32'h0);
        check_value({tag, "_req"},   {31'b0, bus.WR_REQ},  32'h0);
        check_value({tag, "_reg"},   {24'h0, bus.WR_REG},  32'h0);
        check_value({tag, "_data"},  {24'h0, bus.WR_DATA}, 32'h0);
        check_value({tag, "_ready"}, {31'b0, ready},       32'h0);
        check_value({tag, "_error"}, {31'b0, error},       32'h0);
    endtask

    initial begin
        int n;
        int w;
        rom[0]  = 16'h1520; rom[1]  = 16'h1630; rom[2]  = 16'h4110; rom[3]  = 16'h9803;
        rom[4]  = 16'h9AE0; rom[5]  = 16'h9740; rom[6]  = 16'h9C30; rom[7]  = 16'h9D61;
        rom[8]  = 16'hA2A4; rom[9]  = 16'hA3A4; rom[10] = 16'hE0D0; rom[11] = 16'hAF06;
        rom[12] = 16'hBA60; rom[13] = 16'hF900; rom[14] = 16'h0000; rom[15] = 16'h0000;
        clear_plan();
        load_engine();
        RST_n    = 1'b0;
        START    = 1'b0;
        HDMI_INT = 1'b1;

        // Reset values and power-up latency
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        begin_expect();
        model_rom_pass();
        RST_n = 1'b1;
        n = 0;
        while (!bus.WR_REQ && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value("first_req_latency", 32'(n), 32'd5);
        check_value("first_req_reg",  {24'h0, bus.WR_REG},  32'h15);
        check_value("first_req_data", {24'h0, bus.WR_DATA}, 32'h20);

        // Full ACK pass
        wait_settled("ack_all");
        check_value("ack_all_ready_lat", 32'(cyc - last_done_cyc), 32'd2);
        compare_txns("ack_all");
        repeat (10) @(negedge clk);
        check_value("done_addr_hold", {28'h0, cfg_addr}, 32'd13);
        check_value("done_ready_hold", {31'b0, ready}, 32'd1);
        check_value("done_req_idle", {31'b0, bus.WR_REQ}, 32'd0);

        // Entry 5 NACKed twice then ACKed
        clear_plan();
        plan[5] = 2;
        load_engine();
        begin_expect();
        model_rom_pass();
        pulse_start();
        wait_settled("nack5");
        compare_txns("nack5");

        // Entry 2 NACKed beyond the retry budget
        clear_plan();
        plan[2] = MAX_RETRY + 1;
        load_engine();
        begin_expect();
        model_rom_pass();
        pulse_start();
        wait_settled("nack2");
        compare_txns("nack2");
        repeat (20) @(negedge clk);
        check_value("err_no_more_req", 32'(obs_q.size()), 32'(exp_q.size()));
        check_value("err_sticky", {31'b0, error}, 32'd1);
        begin_expect();
        model_rom_pass();
        pulse_start();
        check_value("start_clears_err", {31'b0, error}, 32'd0);
        wait_settled("recover");
        compare_txns("recover");

        // Interrupt while idle in DONE
        begin_expect();
        exp_q.push_back(16'h96C0);
        model_rom_pass();
        @(negedge clk);
        HDMI_INT = 1'b0;
        n = 0;
        while (ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_value("int_ready_fall_lat", 32'(n), 32'd4);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        HDMI_INT = 1'b1;
        wait_settled("int_idle");
        compare_txns("int_idle");

        // Interrupt arriving while entry 7 is in flight
        begin_expect();
        model_rom_pass();
        exp_q.push_back(16'h96C0);
        clear_plan();
        model_rom_pass();
        pulse_start();
        wait_obs("int_mid", 8);
        HDMI_INT = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        HDMI_INT = 1'b1;
        wait_settled("int_mid_first");
        check_value("int_mid_ready_at", 32'(obs_q.size()), 32'(NUM_CFG));
        w = 0;
        while (ready && w < 20) begin
            w++;
            @(negedge clk);
        end
        check_value("int_mid_ready_width", 32'(w), 32'd1);
        wait_settled("int_mid");
        compare_txns("int_mid");

        // START while a write is outstanding
        clear_plan();
        load_engine();
        begin_expect();
        pulse_start();
        wait_obs("start_mid", int'($urandom_range(2, 10)));
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        check_value("start_drops_req", {31'b0, bus.WR_REQ}, 32'd0);
        obs_q.delete();
        model_rom_pass();
        wait_settled("start_mid");
        compare_txns("start_mid");

        // Randomised NACK patterns against the table-walk model
        for (int it = 0; it < 4; it++) begin
            clear_plan();
            for (int i = 0; i < NUM_CFG; i++)
                if ($urandom_range(0, 3) == 0) plan[i] = int'($urandom_range(1, MAX_RETRY));
            if (it == 2) plan[int'($urandom_range(0, NUM_CFG - 1))] = MAX_RETRY + 1;
            load_engine();
            begin_expect();
            model_rom_pass();
            pulse_start();
            wait_settled($sformatf("rand%0d", it));
            compare_txns($sformatf("rand%0d", it));
        end

        // Asynchronous reset while a write is outstanding
        clear_plan();
        load_engine();
        begin_expect();
        pulse_start();
        wait_obs("midreset", 4);
        n = 0;
        while (!bus.WR_REQ && n < 20) begin
            @(negedge clk);
            n++;
        end
        #2;
        RST_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        begin_expect();
        model_rom_pass();
        RST_n = 1'b1;
        wait_settled("after_reset");
        compare_txns("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
